// File: rtl/branch_predict_pcsrc.sv
// ============================================================================
// branch_predict_pcsrc : direct-mapped BTB with saturating direction counters,
//                        execute-stage resolution, PC-source select and perf counters
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predict_pcsrc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_BITS    = 2,
  parameter int PERF_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pcf,
  output logic                  predict_takenf,
  output logic [ADDR_WIDTH-1:0] predict_targetf,
  input  logic                  valid_e,
  input  logic                  branche,
  input  logic                  jale,
  input  logic                  jalre,
  input  logic                  condition_mete,
  input  logic [ADDR_WIDTH-1:0] pce,
  input  logic [ADDR_WIDTH-1:0] targete,
  input  logic                  pred_takene,
  input  logic [ADDR_WIDTH-1:0] pred_targete,
  output logic [1:0]            pcsrc,
  output logic                  flush,
  output logic [PERF_WIDTH-1:0] branch_count,
  output logic [PERF_WIDTH-1:0] mispredict_count
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  localparam logic [1:0] C_PC_SEQ  = 2'b00;
  localparam logic [1:0] C_PC_PRED = 2'b01;
  localparam logic [1:0] C_PC_TGT  = 2'b10;
  localparam logic [1:0] C_PC_FALL = 2'b11;

  localparam logic [CNT_BITS-1:0]   C_CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0]   C_CNT_WT   = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0]   C_CNT_WNT  = C_CNT_WT - CNT_BITS'(1);
  localparam logic [PERF_WIDTH-1:0] C_PERF_MAX = '1;

  logic                  r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]      r_tag    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [BTB_ENTRIES];
  logic [CNT_BITS-1:0]   r_cnt    [BTB_ENTRIES];
  logic [PERF_WIDTH-1:0] r_branch_cnt;
  logic [PERF_WIDTH-1:0] r_mispred_cnt;

  logic [IDX-1:0]        w_fidx;
  logic [IDX-1:0]        w_eidx;
  logic [TAG_W-1:0]      w_etag;
  logic                  w_fhit;
  logic                  w_ehit;
  logic                  w_taken_e;
  logic                  w_redirect;
  logic [1:0]            w_redir_sel;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_target;
  logic [CNT_BITS-1:0]   w_wr_cnt;
  logic                  w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^{pcf[1:0], pce[1:0]};

  // Fetch lookup reads the array before any same-cycle update lands.
  assign w_fidx          = pcf[IDX+1:2];
  assign w_fhit          = r_valid[w_fidx] && (r_tag[w_fidx] == pcf[ADDR_WIDTH-1:IDX+2]);
  assign predict_takenf  = w_fhit && r_cnt[w_fidx][CNT_BITS-1];
  assign predict_targetf = w_fhit ? r_target[w_fidx] : '0;

  assign w_eidx    = pce[IDX+1:2];
  assign w_etag    = pce[ADDR_WIDTH-1:IDX+2];
  assign w_ehit    = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
  assign w_taken_e = jale || (branche && condition_mete);

  always_comb begin
    w_redirect  = 1'b0;
    w_redir_sel = C_PC_TGT;
    if (valid_e) begin
      if (jalre) begin
        w_redirect = 1'b1;
      end else if (w_taken_e) begin
        w_redirect = !pred_takene || (pred_targete != targete);
      end else if (branche && pred_takene) begin
        w_redirect  = 1'b1;
        w_redir_sel = C_PC_FALL;
      end
    end
  end

  assign pcsrc = w_redirect ? w_redir_sel : (predict_takenf ? C_PC_PRED : C_PC_SEQ);
  assign flush = w_redirect;

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_target = targete;
    w_wr_cnt    = r_cnt[w_eidx];
    if (valid_e && !jalre) begin
      if (jale) begin
        w_wr_en  = 1'b1;
        w_wr_cnt = C_CNT_MAX;
      end else if (branche) begin
        if (w_ehit) begin
          w_wr_en = 1'b1;
          if (condition_mete) begin
            w_wr_cnt = (r_cnt[w_eidx] == C_CNT_MAX) ? C_CNT_MAX : r_cnt[w_eidx] + CNT_BITS'(1);
          end else begin
            w_wr_target = r_target[w_eidx];
            w_wr_cnt    = (r_cnt[w_eidx] == '0) ? '0 : r_cnt[w_eidx] - CNT_BITS'(1);
          end
        end else if (condition_mete) begin
          w_wr_en  = 1'b1;
          w_wr_cnt = C_CNT_WT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= C_CNT_WNT;
      end
    end else if (w_wr_en) begin
      r_valid[w_eidx]  <= 1'b1;
      r_tag[w_eidx]    <= w_etag;
      r_target[w_eidx] <= w_wr_target;
      r_cnt[w_eidx]    <= w_wr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (valid_e) begin
      if ((branche || jale || jalre) && (r_branch_cnt != C_PERF_MAX)) begin
        r_branch_cnt <= r_branch_cnt + PERF_WIDTH'(1);
      end
      if (w_redirect && (r_mispred_cnt != C_PERF_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + PERF_WIDTH'(1);
      end
    end
  end

  assign branch_count     = r_branch_cnt;
  assign mispredict_count = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_pcsrc.sv
// ============================================================================
// tb_branch_predict_pcsrc : directed + random scoreboard bench for branch_predict_pcsrc
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predict_pcsrc;

  localparam int AW = 32;
  localparam int NE = 16;
  localparam int CB = 2;
  localparam int PW = 4;
  localparam int SH = 2 + $clog2(NE);
  localparam int CTR_MAX  = (1 << CB) - 1;
  localparam int CTR_WT   = 1 << (CB - 1);
  localparam int PERF_MAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pcf = '0;
  logic          predict_takenf;
  logic [AW-1:0] predict_targetf;
  logic          valid_e = 1'b0, branche = 1'b0, jale = 1'b0, jalre = 1'b0, condition_mete = 1'b0;
  logic [AW-1:0] pce = '0, targete = '0, pred_targete = '0;
  logic          pred_takene = 1'b0;
  logic [1:0]    pcsrc;
  logic          flush;
  logic [PW-1:0] branch_count, mispredict_count;

  branch_predict_pcsrc #(
    .ADDR_WIDTH(AW), .BTB_ENTRIES(NE), .CNT_BITS(CB), .PERF_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcf(pcf),
    .predict_takenf(predict_takenf), .predict_targetf(predict_targetf),
    .valid_e(valid_e), .branche(branche), .jale(jale), .jalre(jalre),
    .condition_mete(condition_mete), .pce(pce), .targete(targete),
    .pred_takene(pred_takene), .pred_targete(pred_targete),
    .pcsrc(pcsrc), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    pcsrc;
    logic          flush;
    logic          ptk;
    logic [AW-1:0] ptg;
    int            bc;
    int            mc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference BTB: keeps the full PC of the allocating instruction per slot.
  bit          m_valid [NE];
  logic [AW-1:0] m_pc  [NE];
  logic [AW-1:0] m_tgt [NE];
  int          m_ctr   [NE];
  int          m_bc, m_mc;

  function automatic int slot(input logic [AW-1:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic bit m_hit(input logic [AW-1:0] pc);
    return m_valid[slot(pc)] && ((m_pc[slot(pc)] >> SH) == (pc >> SH));
  endfunction

  function automatic bit m_takenf(input logic [AW-1:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= CTR_WT);
  endfunction

  function automatic logic [AW-1:0] m_targetf(input logic [AW-1:0] pc);
    return m_hit(pc) ? m_tgt[slot(pc)] : '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = CTR_WT - 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  // kind: 0 = non-control, 1 = branch, 2 = jal, 3 = jalr
  task automatic step(input bit rl, input bit v, input int kind, input bit cond,
                      input logic [AW-1:0] pe, input logic [AW-1:0] tg,
                      input bit ptk, input logic [AW-1:0] ptg, input logic [AW-1:0] pf);
    exp_t e;
    int   redir;
    bit   taken;
    int   s;
    @(posedge clk); #1;
    rst_n = !rl; valid_e = v; branche = (kind == 1); jale = (kind == 2); jalre = (kind == 3);
    condition_mete = cond; pce = pe; targete = tg; pred_takene = ptk; pred_targete = ptg; pcf = pf;
    if (rl) model_reset();
    taken = (kind == 2) || (kind == 1 && cond);
    redir = 0;
    if (v) begin
      if (kind == 3) redir = 2;
      else if (taken) redir = (!ptk || ptg != tg) ? 2 : 0;
      else if (kind == 1 && ptk) redir = 3;
    end
    e.ptk   = m_takenf(pf);
    e.ptg   = m_targetf(pf);
    e.pcsrc = (redir != 0) ? 2'(redir) : (e.ptk ? 2'd1 : 2'd0);
    e.flush = (redir != 0);
    e.bc    = m_bc;
    e.mc    = m_mc;
    q.push_back(e);
    if (!rl && v) begin
      s = slot(pe);
      if (kind == 2) begin
        m_valid[s] = 1'b1; m_pc[s] = pe; m_tgt[s] = tg; m_ctr[s] = CTR_MAX;
      end else if (kind == 1) begin
        if (m_hit(pe)) begin
          if (cond) begin
            if (m_ctr[s] < CTR_MAX) m_ctr[s]++;
            m_tgt[s] = tg;
          end else if (m_ctr[s] > 0) m_ctr[s]--;
        end else if (cond) begin
          m_valid[s] = 1'b1; m_pc[s] = pe; m_tgt[s] = tg; m_ctr[s] = CTR_WT;
        end
      end
      if (kind != 0 && m_bc < PERF_MAX) m_bc++;
      if (redir != 0 && m_mc < PERF_MAX) m_mc++;
    end
  endtask

  // Monitor: one popped expectation per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (pcsrc !== e.pcsrc) begin
          n_err++; $display("FAIL pcsrc vec=%0d got=%0d exp=%0d", n_vec, pcsrc, e.pcsrc);
        end
        if (flush !== e.flush) begin
          n_err++; $display("FAIL flush vec=%0d got=%0b exp=%0b", n_vec, flush, e.flush);
        end
        if (predict_takenf !== e.ptk) begin
          n_err++; $display("FAIL predict_takenf vec=%0d got=%0b exp=%0b", n_vec, predict_takenf, e.ptk);
        end
        if (predict_targetf !== e.ptg) begin
          n_err++; $display("FAIL predict_targetf vec=%0d got=%h exp=%h", n_vec, predict_targetf, e.ptg);
        end
        if (int'(branch_count) != e.bc || $isunknown(branch_count)) begin
          n_err++; $display("FAIL branch_count vec=%0d got=%0d exp=%0d", n_vec, branch_count, e.bc);
        end
        if (int'(mispredict_count) != e.mc || $isunknown(mispredict_count)) begin
          n_err++; $display("FAIL mispredict_count vec=%0d got=%0d exp=%0d", n_vec, mispredict_count, e.mc);
        end
      end
    end
  end

  function automatic logic [AW-1:0] rand_pc();
    case ($urandom_range(0, 6))
      0: return 32'h100;
      1: return 32'h140;
      2: return 32'h200;
      3: return 32'h300;
      4: return 32'h104;
      5: return 32'h180;
      default: return {$urandom} & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    logic [AW-1:0] pe, tg, pf, ptg;
    bit            ptk;
    model_reset();
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    // cold branch, then predicted lookup
    step(0, 1, 1, 1, 32'h100, 32'h80, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    // loop learning with correct feedback, then one not-taken
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 32'h100, 32'h80, 1, 32'h80, 32'h100);
    step(0, 1, 1, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    // jal then jalr
    step(0, 1, 2, 0, 32'h200, 32'h400, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    step(0, 1, 3, 0, 32'h300, 32'h500, 1, 32'h500, 32'h300);
    step(0, 1, 3, 0, 32'h300, 32'h500, 1, 32'h500, 32'h300);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h300);
    // aliasing at one index
    step(0, 1, 1, 1, 32'h140, 32'h90, 0, 0, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 1, 1, 1, 32'h100, 32'h80, 0, 0, 32'h140);
    step(0, 1, 1, 0, 32'h140, 32'h90, 0, 0, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    // redirect storm saturates the counters; redirect beats fetch prediction
    for (int i = 0; i < 20; i++) step(0, 1, 3, 0, 32'h300, 32'h500, 0, 0, 32'h100);
    step(0, 1, 2, 0, 32'h200, 32'h600, 1, 32'h400, 32'h100);
    // mid-run reset, trained PC must miss afterwards
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 32'h200);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      pe = rand_pc();
      pf = rand_pc();
      tg = ($urandom_range(0, 1) == 0) ? 32'h80 : ({$urandom} & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) < 6) begin
        ptk = m_takenf(pe); ptg = m_targetf(pe);
      end else begin
        ptk = 1'($urandom_range(0, 1));
        ptg = ($urandom_range(0, 1) == 0) ? tg : ({$urandom} & 32'hFFFF_FFFC);
      end
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), pe, tg, ptk, ptg, pf);
    end
    @(posedge clk); #1;
    valid_e = 1'b0; rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    if (q.size() != 0) begin
      n_err++; $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
